// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port OTTER memory bus arbiter.
//   arb_state_t : arbiter FSM state encoding
//   arb_port_t  : requester identity (PORT1 = fetch, PORT2 = data)
//   arb_cmd_t   : one registered downstream command
//   FULL_STROBE : byte enables for a full-word access
package mem_arb_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  localparam logic [3:0] FULL_STROBE = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY1 = 3'd1,
    BUSY2 = 3'd2,
    DONE1 = 3'd3,
    DONE2 = 3'd4
  } arb_state_t;

  typedef enum logic {
    PORT1 = 1'b0,
    PORT2 = 1'b1
  } arb_port_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic                  rd;
    logic                  wr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [3:0]            strobe;
  } arb_cmd_t;

endpackage

// File: rtl/mem_arb_cmd_reg.sv
// Grant-time command capture for the memory arbiter.
// On load, the granted port's request is latched and held until the next
// load, so the downstream bus sees a stable command for the whole transaction.
//   MEM_CLK, rst         : clock, async active-low reset
//   load, load_port      : capture strobe and which port is granted
//   addr1                : fetch port address (always a full-word read)
//   rd2, wr2, addr2,
//   wdata2, strobe2      : data port request
//   cmd_*                : registered command fields
module mem_arb_cmd_reg
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              MEM_CLK,
  input  logic              rst,
  input  logic              load,
  input  arb_port_t         load_port,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              rd2,
  input  logic              wr2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [3:0]        strobe2,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_rd,
  output logic              cmd_wr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic [3:0]        cmd_strobe
);

  always_ff @(posedge MEM_CLK or negedge rst) begin
    if (!rst) begin
      cmd_addr   <= '0;
      cmd_rd     <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_wdata  <= '0;
      cmd_strobe <= '0;
    end else if (load) begin
      if (load_port == PORT1) begin
        cmd_addr   <= addr1;
        cmd_rd     <= 1'b1;
        cmd_wr     <= 1'b0;
        cmd_wdata  <= '0;
        cmd_strobe <= FULL_STROBE;
      end else begin
        // rd2 and wr2 together resolve to a write so the bus never
        // carries both commands at once.
        cmd_addr   <= addr2;
        cmd_rd     <= rd2 & ~wr2;
        cmd_wr     <= wr2;
        cmd_wdata  <= wdata2;
        cmd_strobe <= strobe2;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the OTTER memory bus between the instruction
// fetch port (port 1, read-only) and the data port (port 2, read/write).
//   MEM_CLK, rst            : clock, async active-low reset
//   req1/addr1              : port 1 read request and address
//   resp1/rdata1            : port 1 completion pulse and read data
//   rd2/wr2/addr2/wdata2/
//   strobe2                 : port 2 request
//   resp2/rdata2            : port 2 completion pulse and read data
//   mem_*                   : downstream bus (command out, rdata/resp in)
//   conflict_err            : sticky, set when rd2 and wr2 are granted together
//   dbg_state               : current FSM state
//
// Handshake: a requester raises its request and holds it (with stable
// address/data) until its resp pulse; it drops the request in the cycle after
// resp or a new transaction starts. Downstream, mem_read/mem_write stay high
// until mem_resp is seen; mem_resp outside BUSY is ignored.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              MEM_CLK,
  input  logic              rst,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              resp1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              rd2,
  input  logic              wr2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [3:0]        strobe2,
  output logic              resp2,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_byte_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              conflict_err,
  output arb_state_t        dbg_state
);

  arb_state_t        state, state_nxt;
  arb_port_t         last_grant;
  arb_port_t         grant_port;
  logic              grant;
  logic              pend1, pend2;
  logic              busy;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rd, cmd_wr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [3:0]        cmd_strobe;

  // Grant selection: on a tie, the port that did not win last time goes.
  always_comb begin
    pend1 = req1;
    pend2 = rd2 | wr2;
    grant = (state == IDLE) && (pend1 || pend2);
    if (pend1 && pend2) grant_port = (last_grant == PORT1) ? PORT2 : PORT1;
    else if (pend1)     grant_port = PORT1;
    else                grant_port = PORT2;
  end

  // State register.
  always_ff @(posedge MEM_CLK or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = (grant_port == PORT1) ? BUSY1 : BUSY2;
      BUSY1:   if (mem_resp) state_nxt = DONE1;
      BUSY2:   if (mem_resp) state_nxt = DONE2;
      DONE1:   state_nxt = IDLE;
      DONE2:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: the bus carries the command only while BUSY.
  always_comb begin
    busy            = (state == BUSY1) || (state == BUSY2);
    resp1           = (state == DONE1);
    resp2           = (state == DONE2);
    mem_address     = busy ? cmd_addr   : '0;
    mem_read        = busy & cmd_rd;
    mem_write       = busy & cmd_wr;
    mem_wdata       = busy ? cmd_wdata  : '0;
    mem_byte_enable = busy ? cmd_strobe : 4'h0;
    dbg_state       = state;
  end

  // Grant history, response data and the sticky conflict flag.
  always_ff @(posedge MEM_CLK or negedge rst) begin
    if (!rst) begin
      last_grant   <= PORT2;
      rdata1       <= '0;
      rdata2       <= '0;
      conflict_err <= 1'b0;
    end else begin
      if (grant) last_grant <= grant_port;
      if (grant && grant_port == PORT2 && rd2 && wr2) conflict_err <= 1'b1;
      if (state == BUSY1 && mem_resp) rdata1 <= mem_rdata;
      // Writes leave the previous port 2 read data in place.
      if (state == BUSY2 && mem_resp && cmd_rd) rdata2 <= mem_rdata;
    end
  end

  mem_arb_cmd_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmd_reg (
    .MEM_CLK    (MEM_CLK),
    .rst        (rst),
    .load       (grant),
    .load_port  (grant_port),
    .addr1      (addr1),
    .rd2        (rd2),
    .wr2        (wr2),
    .addr2      (addr2),
    .wdata2     (wdata2),
    .strobe2    (strobe2),
    .cmd_addr   (cmd_addr),
    .cmd_rd     (cmd_rd),
    .cmd_wr     (cmd_wr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strobe (cmd_strobe)
  );

endmodule
